// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle for seq_mult_ctrl.
// A transfer happens on a rising edge where valid and ready are both high; a source holds valid and its payload stable until that edge.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Iterative shift-add multiplier: one shared ripple-carry FA chain, up to WIDTH RUN cycles per product.
// Define SEQ_MULT_EARLY_TERM_EN to skip zero operands and stop once no multiplier bits remain.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_mult_ctrl_if.slave   bus,
  output logic [1:0]       fsm_state
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     mcand, mcand_nx;
  logic [WIDTH-1:0]  mplier, mplier_nx;
  logic [PW-1:0]     acc, acc_nx;
  logic [CW-1:0]     cnt, cnt_nx;

  // Shared adder: acc + mcand, carry-in 0; final carry-out is never built since a*b fits in PW bits.
  logic [PW-1:0] sum;
  logic [PW-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PW; i++) begin : g_fa
    assign sum[i] = acc[i] ^ mcand[i] ^ carry[i];
    if (i < PW - 1) begin : g_cout
      assign carry[i+1] = (acc[i] & mcand[i]) | (carry[i] & (acc[i] ^ mcand[i]));
    end
  end

  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    acc_nx    = acc;
    cnt_nx    = cnt;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_nx  = {{WIDTH{1'b0}}, bus.a};
          mplier_nx = bus.b;
          acc_nx    = '0;
          cnt_nx    = '0;
          state_nx  = RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (bus.a == '0 || bus.b == '0) state_nx = DONE;
`endif
        end
      end
      RUN: begin
        if (mplier[0]) acc_nx = sum;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt + CW'(1);
        if (cnt == LAST) state_nx = DONE;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (mplier[WIDTH-1:1] == '0) state_nx = DONE;
`endif
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = acc;
  assign fsm_state     = state;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed table plus corner sequences and a randomized stream for seq_mult_ctrl (WIDTH=8).
// Expected latencies follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_mult_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] fsm_state;

  seq_mult_ctrl_if #(.WIDTH(W)) bus ();

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat_off;
    int             lat_en;
    int             bp;
  } vec_t;

  vec_t vecs[11];
  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One operation: accept, count edges to out_valid, hold off for bp cycles, then take.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p, input int exp_lat, input int bp);
    int lat;
    int waitc;
    logic [2*W-1:0] held;
    @(negedge clk);
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_op", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    check("in_ready_after_accept", {31'b0, bus.in_ready}, 32'd0);
    while (!bus.out_valid && lat < 64) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom_range(0, 255));
      bus.b = W'($urandom_range(0, 255));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
    check("latency", lat, exp_lat);
    check("product", {16'b0, bus.product}, {16'b0, exp_p});
    held = bus.product;
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = W'($urandom_range(0, 255));
      bus.b = W'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
      check("bp_product_stable", {16'b0, bus.product}, {16'b0, held});
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_take", {31'b0, bus.out_valid}, 32'd0);
    check("in_ready_after_take", {31'b0, bus.in_ready}, 32'd1);
    check("busy_after_take", {31'b0, bus.busy}, 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int accepted;
    int taken;
    int cyc;
    logic [2*W-1:0] p;

    vecs[0]  = '{8'd13,  8'd11,  16'h008F, 8, 4, 0};
    vecs[1]  = '{8'd255, 8'd255, 16'hFE01, 8, 8, 5};
    vecs[2]  = '{8'd0,   8'd200, 16'h0000, 8, 0, 0};
    vecs[3]  = '{8'd7,   8'd9,   16'h003F, 8, 4, 0};
    vecs[4]  = '{8'd1,   8'd1,   16'h0001, 8, 1, 0};
    vecs[5]  = '{8'd3,   8'h80,  16'h0180, 8, 8, 2};
    vecs[6]  = '{8'd255, 8'd1,   16'h00FF, 8, 1, 0};
    vecs[7]  = '{8'd1,   8'd255, 16'h00FF, 8, 8, 0};
    vecs[8]  = '{8'd200, 8'd0,   16'h0000, 8, 0, 1};
    vecs[9]  = '{8'd16,  8'd16,  16'h0100, 8, 5, 0};
    vecs[10] = '{8'd170, 8'd85,  16'h3872, 8, 7, 3};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_product", {16'b0, bus.product}, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset_state", {30'b0, fsm_state}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat_en, vecs[i].bp);
`else
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat_off, vecs[i].bp);
`endif
    end

    // Abort an operation after three RUN edges, then confirm a clean restart.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'd200;
    bus.b = 8'd255;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrun_reset_product", {16'b0, bus.product}, 32'd0);
    check("midrun_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    run_op(8'd7, 8'd9, 16'h003F, 4, 0);
`else
    run_op(8'd7, 8'd9, 16'h003F, 8, 0);
`endif

    // Streaming: in_valid held high, random backpressure, scoreboard order check.
    accepted = 0;
    taken = 0;
    cyc = 0;
    while ((accepted < 1000 || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (accepted < 1000) begin
        bus.in_valid = 1'b1;
        bus.a = W'($urandom_range(0, 255));
        bus.b = W'($urandom_range(0, 255));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({8'b0, bus.a} * {8'b0, bus.b});
        accepted++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_output", 32'd1, 32'd0);
        end else begin
          p = exp_q.pop_front();
          check("rand_product", {16'b0, bus.product}, {16'b0, p});
          taken++;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_no_timeout", {31'b0, (cyc < 60000)}, 32'd1);
    check("rand_taken", taken, 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
